// File: rtl/pll_lock_seq_pkg.sv
// Shared types and defaults for the PLL lock sequencer (optional CE generator: PLL_LOCK_SEQ_CE_EN).
package pll_lock_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        REL_MEM   = 2'd2,
        RUN       = 2'd3
    } state_e;

    localparam int LOSS_CNT_W        = 8;
    localparam int STABLE_CYCLES_DEF = 1024;
    localparam int STAGE_GAP_DEF     = 16;
    localparam int CE_NUM_DEF        = 1;
    localparam int CE_DEN_DEF        = 5;

    // Width of a counter that runs 0 .. n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pll_lock_seq_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_seq.sv
// Staged reset release after PLL lock, with lock-loss tracking and a clock enable.
// Macro PLL_LOCK_SEQ_CE_EN selects the fractional CE generator; otherwise ce_out = ~core_rst.
module pll_lock_seq
    import pll_lock_seq_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int STAGE_GAP     = STAGE_GAP_DEF,
    parameter int CE_NUM        = CE_NUM_DEF,
    parameter int CE_DEN        = CE_DEN_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  locked_in,
    output logic                  mem_rst,
    output logic                  core_rst,
    output logic                  ce_out,
    output logic                  lock_lost,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int                STAB_W    = cnt_width(STABLE_CYCLES);
    localparam int                GAP_W     = cnt_width(STAGE_GAP);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);

    if (STABLE_CYCLES < 1 || STAGE_GAP < 1) begin : g_bad_timing
        $error("pll_lock_seq: STABLE_CYCLES and STAGE_GAP must be at least 1");
    end
    if (CE_NUM < 1 || CE_DEN < 1 || CE_NUM > CE_DEN) begin : g_bad_ce_ratio
        $error("pll_lock_seq: CE ratio must satisfy 1 <= CE_NUM <= CE_DEN");
    end

    logic                  locked_s;
    state_e                state_q, state_d;
    logic [STAB_W-1:0]     stab_cnt_q, stab_cnt_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic                  mem_rst_q, mem_rst_d;
    logic                  core_rst_q, core_rst_d;
    logic                  lost_q, lost_d;
    logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
    logic                  ce_q, ce_d;
    logic                  loss;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (locked_in),
        .q_o (locked_s)
    );

    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        lost_d     = lost_q;
        loss_cnt_d = loss_cnt_q;
        loss       = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d    = STABILIZE;
                    stab_cnt_d = '0;
                end
            end
            STABILIZE: begin
                // A drop here just restarts the wait; only released resets count as losses.
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (stab_cnt_q == STAB_LAST) begin
                    state_d   = REL_MEM;
                    gap_cnt_d = '0;
                end else begin
                    stab_cnt_d = stab_cnt_q + 1'b1;
                end
            end
            REL_MEM: begin
                if (!locked_s) begin
                    loss = 1'b1;
                end else if (gap_cnt_q == GAP_LAST) begin
                    state_d = RUN;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    loss = 1'b1;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase

        if (loss) begin
            state_d = WAIT_LOCK;
            lost_d  = 1'b1;
            if (loss_cnt_q != '1) begin
                loss_cnt_d = loss_cnt_q + 1'b1;
            end
        end

        // Reset outputs are decoded from the next state so they flip on the same edge as the state.
        mem_rst_d  = !(state_d == REL_MEM || state_d == RUN);
        core_rst_d = (state_d != RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_LOCK;
            stab_cnt_q <= '0;
            gap_cnt_q  <= '0;
            mem_rst_q  <= 1'b1;
            core_rst_q <= 1'b1;
            lost_q     <= 1'b0;
            loss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            stab_cnt_q <= stab_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            mem_rst_q  <= mem_rst_d;
            core_rst_q <= core_rst_d;
            lost_q     <= lost_d;
            loss_cnt_q <= loss_cnt_d;
        end
    end

`ifdef PLL_LOCK_SEQ_CE_EN
    localparam int ACC_W = $clog2(CE_DEN) + 1;

    logic [ACC_W-1:0] acc_q, acc_d, acc_sum;

    // Held while core_rst is (or is about to be) asserted, so the first pulse lands DEN/NUM cycles after release.
    always_comb begin
        acc_sum = acc_q + ACC_W'(CE_NUM);
        acc_d   = acc_sum;
        ce_d    = 1'b0;
        if (core_rst_q || core_rst_d) begin
            acc_d = '0;
        end else if (acc_sum >= ACC_W'(CE_DEN)) begin
            acc_d = acc_sum - ACC_W'(CE_DEN);
            ce_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    assign ce_d = ~core_rst_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ce_q <= 1'b0;
        end else begin
            ce_q <= ce_d;
        end
    end

    assign mem_rst       = mem_rst_q;
    assign core_rst      = core_rst_q;
    assign ce_out        = ce_q;
    assign lock_lost     = lost_q;
    assign lock_loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Self-checking bench for pll_lock_seq: directed sequences plus random lock traffic vs a run-length model.
module tb_pll_lock_seq;

    localparam int S   = 8;
    localparam int G   = 4;
    localparam int NUM = 1;
    localparam int DEN = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked_in = 1'b0;
    logic       mem_rst;
    logic       core_rst;
    logic       ce_out;
    logic       lock_lost;
    logic [7:0] lock_loss_cnt;

    pll_lock_seq #(
        .STABLE_CYCLES (S),
        .STAGE_GAP     (G),
        .CE_NUM        (NUM),
        .CE_DEN        (DEN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .locked_in     (locked_in),
        .mem_rst       (mem_rst),
        .core_rst      (core_rst),
        .ce_out        (ce_out),
        .lock_lost     (lock_lost),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int e_cnt    = 0;
    int last_e   = 0;

    // Model state: 2-deep history of sampled lock, consecutive synchronized-lock run length, loss bookkeeping.
    int h1 = 0;
    int h2 = 0;
    int run_len = 0;
    int m_lost = 0;
    int m_loss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Run length needed: S+1 synchronized-lock samples release mem, S+G+1 release core.
    function automatic logic exp_ce(input int r);
        int m;
        m = r - (S + G + 1);
`ifdef PLL_LOCK_SEQ_CE_EN
        if (m < 1) return 1'b0;
        return ((m * NUM) / DEN) != (((m - 1) * NUM) / DEN);
`else
        return m >= 0;
`endif
    endfunction

    task automatic step(input logic lin, input logic r);
        int seen;
        locked_in = lin;
        rst       = r;
        @(posedge clk);
        last_e = e_cnt;
        e_cnt++;
        if (r) begin
            h1 = 0; h2 = 0; run_len = 0; m_lost = 0; m_loss = 0;
        end else begin
            seen = h2;
            h2   = h1;
            h1   = int'(lin);
            if (seen != 0) begin
                run_len++;
            end else begin
                if (run_len >= S + 1) begin
                    m_lost = 1;
                    if (m_loss < 255) m_loss++;
                end
                run_len = 0;
            end
        end
        #1;
        chk("mem_rst",       32'(mem_rst),  32'(run_len < S + 1));
        chk("core_rst",      32'(core_rst), 32'(run_len < S + G + 1));
        chk("ce_out",        32'(ce_out),   32'(exp_ce(run_len)));
        chk("lock_lost",     32'(lock_lost), m_lost);
        chk("lock_loss_cnt", 32'(lock_loss_cnt), m_loss);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int first_e;
        int prev_e;
        int waited;
        int d;
        int exp_pulses;
        int exp_first;
        int exp_period;

`ifdef PLL_LOCK_SEQ_CE_EN
        exp_pulses = 10; exp_first = 19; exp_period = 5;
`else
        exp_pulses = 50; exp_first = 15; exp_period = 1;
`endif

        // Reset state
        repeat (3) step(1'b0, 1'b1);
        $display("reset: mem_rst=%0b core_rst=%0b ce_out=%0b lock_loss_cnt=%0d", mem_rst, core_rst, ce_out, lock_loss_cnt);

        // Lock at edge 0: mem release at edge 10, core at edge 14
        e_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            step(1'b1, 1'b0);
            if (last_e == 9)  chk("mem_rst_e9",   32'(mem_rst),  32'd1);
            if (last_e == 10) chk("mem_rst_e10",  32'(mem_rst),  32'd0);
            if (last_e == 13) chk("core_rst_e13", 32'(core_rst), 32'd1);
            if (last_e == 14) chk("core_rst_e14", 32'(core_rst), 32'd0);
        end
        $display("release: mem_rst=%0b core_rst=%0b at edge %0d", mem_rst, core_rst, last_e);

        // 50 RUN cycles of clock enable
        pulses = 0; first_e = -1; prev_e = -1;
        for (int k = 0; k < 50; k++) begin
            step(1'b1, 1'b0);
            if (ce_out === 1'b1) begin
                pulses++;
                if (first_e < 0) first_e = last_e;
                if (prev_e >= 0) chk("ce_period", last_e - prev_e, exp_period);
                prev_e = last_e;
            end
        end
        chk("ce_pulse_count", pulses, exp_pulses);
        chk("ce_first_pulse", first_e, exp_first);
        $display("ce: pulses=%0d first_edge=%0d", pulses, first_e);

        // Reset pulsed mid-RUN, then the sequence repeats
        step(1'b1, 1'b1);
        chk("rst_mid_run_mem",  32'(mem_rst),  32'd1);
        chk("rst_mid_run_core", 32'(core_rst), 32'd1);
        chk("rst_mid_run_cnt",  32'(lock_loss_cnt), 32'd0);
        e_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            step(1'b1, 1'b0);
            if (last_e == 10) chk("rerun_mem_e10",  32'(mem_rst),  32'd0);
            if (last_e == 13) chk("rerun_core_e13", 32'(core_rst), 32'd1);
            if (last_e == 14) chk("rerun_core_e14", 32'(core_rst), 32'd0);
        end
        chk("rerun_loss_cnt", 32'(lock_loss_cnt), 32'd0);
        $display("rst mid-run: core_rst=%0b lock_loss_cnt=%0d", core_rst, lock_loss_cnt);

        // One-cycle drop while STABILIZE count is 5: relock at edge 7 -> release at 17
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        e_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            step(k != 6, 1'b0);
            if (last_e == 16) chk("stab_drop_mem_e16",  32'(mem_rst),  32'd1);
            if (last_e == 17) chk("stab_drop_mem_e17",  32'(mem_rst),  32'd0);
            if (last_e == 21) chk("stab_drop_core_e21", 32'(core_rst), 32'd0);
        end
        chk("stab_drop_loss_cnt", 32'(lock_loss_cnt), 32'd0);
        chk("stab_drop_lost",     32'(lock_lost),     32'd0);
        $display("stabilize drop: mem_rst=%0b lock_loss_cnt=%0d", mem_rst, lock_loss_cnt);

        // Random lock traffic with occasional reset
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 15) != 0, $urandom_range(0, 199) == 0);
        end
        $display("random: lock_lost=%0b lock_loss_cnt=%0d", lock_lost, lock_loss_cnt);

        // 300 losses from RUN: counter saturates at 255
        step(1'b1, 1'b1);
        for (int i = 0; i < 300; i++) begin
            waited = 0;
            while (core_rst !== 1'b0 && waited < 40) begin
                step(1'b1, 1'b0);
                waited++;
            end
            chk("run_reached", 32'(core_rst), 32'd0);
            repeat ($urandom_range(0, 5)) step(1'b1, 1'b0);
            d = $urandom_range(1, 3);
            step(1'b0, 1'b0);
            step(d >= 2 ? 1'b0 : 1'b1, 1'b0);
            step(d >= 3 ? 1'b0 : 1'b1, 1'b0);
            chk("loss_mem_rst",  32'(mem_rst),  32'd1);
            chk("loss_core_rst", 32'(core_rst), 32'd1);
            $display("loss %0d: drop_len=%0d lock_loss_cnt=%0d", i + 1, d, lock_loss_cnt);
        end
        chk("final_lock_lost", 32'(lock_lost),     32'd1);
        chk("final_loss_cnt",  32'(lock_loss_cnt), 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
